// File: rtl/otp_ctrl_part_rd_pkg.sv
// Shared types for the partition reader: partition descriptor, FSM states
// and the even-parity check helper.
package otp_ctrl_part_pkg;

    typedef struct packed {
        int num_blocks;
    } part_info_t;

    localparam part_info_t PartInfoDefault = part_info_t'(16);

    // Widest block the parity helper accepts; narrower blocks are zero-extended.
    localparam int MaxBlockW = 64;

    typedef enum logic [1:0] {
        Idle = 2'd0,
        Scan = 2'd1,
        Done = 2'd2
    } part_rd_state_e;

    // High when the stored even-parity bit does not match the block contents.
    function automatic logic even_par_err(input logic [MaxBlockW-1:0] block,
                                          input logic                 par);
        return (^block) ^ par;
    endfunction

endpackage

// File: rtl/otp_ctrl_part_rd_sel.sv
// Combinational block selector: picks the snapshot block and its parity bit
// at the given index and flags a parity mismatch.
module otp_ctrl_part_rd_sel
    import otp_ctrl_part_pkg::*;
#(
    parameter int NumBlocks = 16,
    parameter int BlockW    = 8,
    parameter int IdxW      = 4
) (
    input  logic [NumBlocks*BlockW-1:0] i_data,
    input  logic [NumBlocks-1:0]        i_par,
    input  logic [IdxW-1:0]             i_idx,
    output logic [BlockW-1:0]           o_data,
    output logic                        o_err
);

    logic [BlockW-1:0] w_blk;
    logic              w_par;

    // Index mux written as a loop so non-power-of-two partitions need no range guard.
    always_comb begin
        w_blk = '0;
        w_par = 1'b0;
        for (int k = 0; k < NumBlocks; k++) begin
            if (i_idx == IdxW'(k)) begin
                w_blk = i_data[k*BlockW +: BlockW];
                w_par = i_par[k];
            end
        end
    end

    assign o_data = w_blk;
    assign o_err  = even_par_err({{(MaxBlockW-BlockW){1'b0}}, w_blk}, w_par);

endmodule

// File: rtl/otp_ctrl_part_rd.sv
// Partition reader: snapshots a partition on start_i and streams it out one
// block per valid/ready handshake, low index first, counting parity errors.
//
//  state | meaning
//  Idle  | waiting for start_i; err_cnt_o holds the last scan result
//  Scan  | presenting snapshot block at r_idx, advancing on each handshake
//  Done  | one-cycle done_o pulse, then back to Idle
module otp_ctrl_part_rd
    import otp_ctrl_part_pkg::*;
#(
    parameter part_info_t Info   = PartInfoDefault,
    parameter int         BlockW = 8,
    localparam int        NumBlocks = Info.num_blocks,
    localparam int        IdxW      = (NumBlocks > 1) ? $clog2(NumBlocks) : 1,
    localparam int        CntW      = $clog2(NumBlocks + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        start_i,
    input  logic [NumBlocks*BlockW-1:0] data_i,
    input  logic [NumBlocks-1:0]        par_i,
    output logic                        rd_valid_o,
    input  logic                        rd_ready_i,
    output logic [BlockW-1:0]           rd_data_o,
    output logic [IdxW-1:0]             rd_idx_o,
    output logic                        rd_err_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [CntW-1:0]             err_cnt_o
);

    part_rd_state_e              r_state;
    part_rd_state_e              w_state_nxt;
    logic [NumBlocks*BlockW-1:0] r_snap_data;
    logic [NumBlocks-1:0]        r_snap_par;
    logic [IdxW-1:0]             r_idx;
    logic [CntW-1:0]             r_err_cnt;

    logic [BlockW-1:0]           w_sel_data;
    logic                        w_sel_err;
    logic                        w_hs;
    logic                        w_last;
    logic                        w_start;

    assign w_start = (r_state == Idle) && start_i;
    assign w_hs    = rd_valid_o && rd_ready_i;
    assign w_last  = (r_idx == IdxW'(NumBlocks - 1));

    otp_ctrl_part_rd_sel #(
        .NumBlocks (NumBlocks),
        .BlockW    (BlockW),
        .IdxW      (IdxW)
    ) u_sel (
        .i_data (r_snap_data),
        .i_par  (r_snap_par),
        .i_idx  (r_idx),
        .o_data (w_sel_data),
        .o_err  (w_sel_err)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= Idle;
        else         r_state <= w_state_nxt;
    end

    // Next-state logic; start_i outside Idle is ignored.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            Idle:    if (start_i) w_state_nxt = Scan;
            Scan:    if (w_hs && w_last) w_state_nxt = Done;
            Done:    w_state_nxt = Idle;
            default: w_state_nxt = Idle;
        endcase
    end

    // Outputs; block fields are forced to zero outside Scan.
    always_comb begin
        rd_valid_o = (r_state == Scan);
        busy_o     = (r_state == Scan);
        done_o     = (r_state == Done);
        rd_data_o  = rd_valid_o ? w_sel_data : '0;
        rd_idx_o   = rd_valid_o ? r_idx      : '0;
        rd_err_o   = rd_valid_o && w_sel_err;
    end

    assign err_cnt_o = r_err_cnt;

    // Snapshot capture, index advance and error counting.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_snap_data <= '0;
            r_snap_par  <= '0;
            r_idx       <= '0;
            r_err_cnt   <= '0;
        end else if (w_start) begin
            r_snap_data <= data_i;
            r_snap_par  <= par_i;
            r_idx       <= '0;
            r_err_cnt   <= '0;
        end else if (w_hs) begin
            if (w_sel_err) r_err_cnt <= r_err_cnt + CntW'(1);
            if (!w_last)   r_idx     <= r_idx + IdxW'(1);
        end
    end

endmodule

// File: tb/tb_otp_ctrl_part_rd.sv
// Bench for otp_ctrl_part_rd: a 16-block instance checked every cycle
// against a transaction-level model, plus a 1-block instance checked directly.
module tb_otp_ctrl_part_rd;
    import otp_ctrl_part_pkg::*;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         start = 1'b0;
    logic [127:0] data = '0;
    logic [15:0]  par = '0;
    logic         rd_ready = 1'b1;
    logic         rd_valid, rd_err, busy, done;
    logic [7:0]   rd_data;
    logic [3:0]   rd_idx;
    logic [4:0]   err_cnt;

    logic         start1 = 1'b0;
    logic [7:0]   data1 = 8'h5A;
    logic         par1 = 1'b0;
    logic         rd_valid1, rd_err1, busy1, done1;
    logic [7:0]   rd_data1;
    logic         rd_idx1;
    logic         err_cnt1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    otp_ctrl_part_rd dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start), .data_i(data), .par_i(par),
        .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
        .rd_idx_o(rd_idx), .rd_err_o(rd_err), .busy_o(busy), .done_o(done),
        .err_cnt_o(err_cnt)
    );

    otp_ctrl_part_rd #(.Info(part_info_t'(1))) dut1 (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start1), .data_i(data1), .par_i(par1),
        .rd_valid_o(rd_valid1), .rd_ready_i(rd_ready), .rd_data_o(rd_data1),
        .rd_idx_o(rd_idx1), .rd_err_o(rd_err1), .busy_o(busy1), .done_o(done1),
        .err_cnt_o(err_cnt1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model of the 16-block reader.
    bit        m_scan, m_done;
    int        m_pos, m_cnt;
    bit [7:0]  m_data [16];
    bit        m_par [16];

    // Observations for directed checks.
    int        first_valid, last_valid, done_cyc, done_cnt, hs_cnt;
    logic [15:0] err_mask;

    task automatic clear_obs();
        first_valid = -1; last_valid = -1; done_cyc = -1; hs_cnt = 0; err_mask = '0;
    endtask

    always @(negedge clk) begin
        bit exp_err;
        if (!rst_ni) begin
            m_scan = 0; m_done = 0; m_pos = 0; m_cnt = 0;
        end
        chk("valid", {31'd0, rd_valid}, {31'd0, m_scan});
        chk("busy", {31'd0, busy}, {31'd0, m_scan});
        chk("done", {31'd0, done}, {31'd0, m_done});
        chk("err_cnt", {27'd0, err_cnt}, m_cnt);
        if (m_scan) begin
            exp_err = (($countones(m_data[m_pos]) + int'(m_par[m_pos])) % 2) == 1;
            chk("idx", {28'd0, rd_idx}, m_pos);
            chk("data", {24'd0, rd_data}, {24'd0, m_data[m_pos]});
            chk("err", {31'd0, rd_err}, {31'd0, exp_err});
        end
        if (rd_valid) begin
            if (first_valid < 0) first_valid = cyc;
            last_valid = cyc;
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (rd_valid && rd_ready) begin
            hs_cnt++;
            if (rd_err) err_mask[rd_idx] = 1'b1;
        end
        // Advance the model to what the coming edge will produce.
        if (rst_ni) begin
            if (m_done) m_done = 0;
            else if (m_scan) begin
                if (rd_ready) begin
                    if ((($countones(m_data[m_pos]) + int'(m_par[m_pos])) % 2) == 1) m_cnt++;
                    if (m_pos == 15) begin m_scan = 0; m_done = 1; end
                    else m_pos++;
                end
            end else if (start) begin
                for (int k = 0; k < 16; k++) begin
                    m_data[k] = data[k*8 +: 8];
                    m_par[k]  = par[k];
                end
                m_pos = 0; m_cnt = 0; m_scan = 1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_start();
        start = 1'b1; step(1); start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int d0 = done_cnt;
        for (int i = 0; i < 80; i++) begin
            if (done_cnt != d0) break;
            step(1);
        end
        chk({name, "_done_seen"}, {31'd0, done_cnt != d0}, 32'd1);
        step(2);
    endtask

    task automatic wait_idx(input string name, input logic [3:0] idx);
        bit hit = 0;
        for (int i = 0; i < 40; i++) begin
            if (rd_valid && rd_idx == idx) begin hit = 1; break; end
            step(1);
        end
        chk({name, "_reach_idx"}, {31'd0, hit}, 32'd1);
    endtask

    task automatic load_clean();
        for (int k = 0; k < 16; k++) begin
            data[k*8 +: 8] = 8'(k);
            par[k] = ^(8'(k));
        end
    endtask

    initial begin
        int s, d0;
        load_clean();
        step(3);
        chk("rst_valid", {31'd0, rd_valid}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_data", {24'd0, rd_data}, 0);
        chk("rst_idx", {28'd0, rd_idx}, 0);
        chk("rst_cnt1", {31'd0, err_cnt1}, 0);
        rst_ni = 1'b1;

        // Clean scan, start at cycle 10.
        while (cyc < 10) step(1);
        clear_obs();
        s = cyc;
        pulse_start();
        wait_done("clean");
        chk("clean_first_valid", first_valid, 11);
        chk("clean_last_valid", last_valid, 26);
        chk("clean_done_cyc", done_cyc, 27);
        chk("clean_hs", hs_cnt, 16);
        chk("clean_errmask", {16'd0, err_mask}, 0);
        chk("clean_errcnt", {27'd0, err_cnt}, 0);
        chk("clean_start_cyc", s, 10);

        // Parity errors on blocks 3 and 15.
        par[3] = ~par[3]; par[15] = ~par[15];
        clear_obs();
        pulse_start();
        wait_done("par");
        chk("par_errmask", {16'd0, err_mask}, 32'h8008);
        chk("par_errcnt", {27'd0, err_cnt}, 2);
        load_clean();

        // Backpressure at idx 7.
        clear_obs();
        pulse_start();
        wait_idx("bp", 4'd7);
        rd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("bp_valid", {31'd0, rd_valid}, 1);
            chk("bp_idx", {28'd0, rd_idx}, 7);
            chk("bp_data", {24'd0, rd_data}, 7);
            chk("bp_err", {31'd0, rd_err}, 0);
        end
        rd_ready = 1'b1;
        wait_done("bp");
        chk("bp_hs", hs_cnt, 16);

        // Start while busy and snapshot isolation.
        clear_obs();
        d0 = done_cnt;
        pulse_start();
        data = {16{8'hFF}};
        wait_idx("busy", 4'd4);
        pulse_start();
        wait_done("busy");
        step(5);
        chk("busy_done_count", done_cnt - d0, 1);
        chk("busy_hs", hs_cnt, 16);
        chk("busy_no_restart", {31'd0, rd_valid}, 0);
        chk("busy_errcnt", {27'd0, err_cnt}, 0);
        load_clean();

        // Reset mid-scan.
        par[2] = ~par[2];
        pulse_start();
        step(3);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, rd_valid}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_done", {31'd0, done}, 0);
        chk("mid_rst_data", {24'd0, rd_data}, 0);
        chk("mid_rst_idx", {28'd0, rd_idx}, 0);
        chk("mid_rst_err", {31'd0, rd_err}, 0);
        chk("mid_rst_cnt", {27'd0, err_cnt}, 0);
        d0 = done_cnt;
        step(2);
        rst_ni = 1'b1;
        step(1);
        chk("mid_rst_no_done", done_cnt - d0, 0);
        load_clean();
        clear_obs();
        pulse_start();
        chk("restart_valid", {31'd0, rd_valid}, 1);
        chk("restart_idx", {28'd0, rd_idx}, 0);
        wait_done("restart");
        chk("restart_hs", hs_cnt, 16);

        // Single-block partition: 0x5A has even weight, so par=0 is correct.
        for (int run = 0; run < 2; run++) begin
            par1 = (run == 1);
            start1 = 1'b1; step(1); start1 = 1'b0;
            chk("n1_valid", {31'd0, rd_valid1}, 1);
            chk("n1_busy", {31'd0, busy1}, 1);
            chk("n1_idx", {31'd0, rd_idx1}, 0);
            chk("n1_data", {24'd0, rd_data1}, 32'h5A);
            chk("n1_err", {31'd0, rd_err1}, run);
            step(1);
            chk("n1_done", {31'd0, done1}, 1);
            chk("n1_valid_off", {31'd0, rd_valid1}, 0);
            step(1);
            chk("n1_done_off", {31'd0, done1}, 0);
            chk("n1_errcnt", {31'd0, err_cnt1}, run);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        done_cnt = 0;
        clear_obs();
    end

endmodule
